pram_rd_arbiter: RTL and testbench

- Shares the single palette-RAM read port between two requesters.
  - The HDMI video output has fixed, unstallable pixel timing.
  - The host (CPU/debug) does readback through a req/gnt handshake.
- Video always wins. Host reads are slotted into idle cycles, and each host wait is bounded by a timeout.
- Tracks which requester owns each in-flight read and steers returned data to it.
- Sits between the video output path and the palette RAM inside the HDMI generator.

---
 rtl/pram_rd_arbiter.sv | 133 +++++++++++++
 tb/tb_pram_rd_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pram_rd_arbiter.sv
// Palette-RAM read-port arbiter: fixed-timing video reads always win, host
// readback is slotted into idle cycles with a bounded wait, and return data is steered by owner.
module pram_rd_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int RD_LAT       = 1,
   parameter int HOST_TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_rd_en,
   input  logic [ADDR_W-1:0] vid_rd_addr,
   output logic              vid_rd_valid,
   output logic [DATA_W-1:0] vid_rd_data,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_timeout,
   output logic [ADDR_W-1:0] ram_rdaddr,
   input  logic [DATA_W-1:0] ram_rddata
);

   localparam int CNT_W = $clog2(HOST_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT     = 2'd1,
      S_INFLIGHT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_hold_q;
   logic [RD_LAT-1:0]  pipe_vld_q;
   logic [RD_LAT-1:0]  pipe_host_q;
   logic               host_issue;
   logic               timeout_hit;
   logic               issue;

   // Host FSM; a host issue is only ever raised in a cycle without a video read.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      host_issue  = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (host_req) begin
               if (!vid_rd_en) begin
                  host_issue = 1'b1;
                  state_d    = S_INFLIGHT;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         S_WAIT: begin
            if (!host_req) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (!vid_rd_en) begin
               host_issue = 1'b1;
               state_d    = S_INFLIGHT;
               cnt_d      = '0;
            end else if (cnt_q == CNT_W'(HOST_TIMEOUT)) begin
               timeout_hit = 1'b1;
               state_d     = S_IDLE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_INFLIGHT: begin
            if (host_rvalid) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign host_gnt     = host_issue & ~rst;
   assign host_timeout = timeout_hit & ~rst;
   assign issue        = vid_rd_en | host_issue;

   // Port address is forced to 0 while reset is held so the RAM sees a quiet bus.
   always_comb begin
      ram_rdaddr = addr_hold_q;
      if (rst)             ram_rdaddr = '0;
      else if (vid_rd_en)  ram_rdaddr = vid_rd_addr;
      else if (host_issue) ram_rdaddr = host_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_hold_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (issue) addr_hold_q <= ram_rdaddr;
      end
   end

   // Owner pipeline: RD_LAT stages track the RAM, the output registers form the last stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld_q   <= '0;
         pipe_host_q  <= '0;
         vid_rd_valid <= 1'b0;
         host_rvalid  <= 1'b0;
         vid_rd_data  <= '0;
         host_rdata   <= '0;
      end else begin
         pipe_vld_q[0]  <= issue;
         pipe_host_q[0] <= host_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_host_q[i] <= pipe_host_q[i-1];
         end
         vid_rd_valid <= pipe_vld_q[RD_LAT-1] & ~pipe_host_q[RD_LAT-1];
         host_rvalid  <= pipe_vld_q[RD_LAT-1] &  pipe_host_q[RD_LAT-1];
         if (pipe_vld_q[RD_LAT-1] && !pipe_host_q[RD_LAT-1]) vid_rd_data <= ram_rddata;
         if (pipe_vld_q[RD_LAT-1] &&  pipe_host_q[RD_LAT-1]) host_rdata  <= ram_rddata;
      end
   end

endmodule

// File: tb/tb_pram_rd_arbiter.sv
// Directed bench for pram_rd_arbiter: instance a uses the default timeout,
// instance b uses HOST_TIMEOUT=4; both share stimulus, each has its own RAM model.
module tb_pram_rd_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              vid_rd_en;
   logic [ADDR_W-1:0] vid_rd_addr;
   logic              host_req;
   logic [ADDR_W-1:0] host_addr;

   logic              vid_rd_valid_a, host_gnt_a, host_rvalid_a, host_timeout_a;
   logic [DATA_W-1:0] vid_rd_data_a, host_rdata_a, ram_rddata_a;
   logic [ADDR_W-1:0] ram_rdaddr_a;
   logic              vid_rd_valid_b, host_gnt_b, host_rvalid_b, host_timeout_b;
   logic [DATA_W-1:0] vid_rd_data_b, host_rdata_b, ram_rddata_b;
   logic [ADDR_W-1:0] ram_rdaddr_b;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   pram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst),
      .vid_rd_en(vid_rd_en), .vid_rd_addr(vid_rd_addr),
      .vid_rd_valid(vid_rd_valid_a), .vid_rd_data(vid_rd_data_a),
      .host_req(host_req), .host_addr(host_addr),
      .host_gnt(host_gnt_a), .host_rvalid(host_rvalid_a),
      .host_rdata(host_rdata_a), .host_timeout(host_timeout_a),
      .ram_rdaddr(ram_rdaddr_a), .ram_rddata(ram_rddata_a)
   );

   pram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .HOST_TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst),
      .vid_rd_en(vid_rd_en), .vid_rd_addr(vid_rd_addr),
      .vid_rd_valid(vid_rd_valid_b), .vid_rd_data(vid_rd_data_b),
      .host_req(host_req), .host_addr(host_addr),
      .host_gnt(host_gnt_b), .host_rvalid(host_rvalid_b),
      .host_rdata(host_rdata_b), .host_timeout(host_timeout_b),
      .ram_rdaddr(ram_rdaddr_b), .ram_rddata(ram_rddata_b)
   );

   // Palette RAM models with one cycle of read latency.
   always @(posedge clk) begin
      ram_rddata_a <= mem[ram_rdaddr_a];
      ram_rddata_b <= mem[ram_rdaddr_b];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[10'h005] = 32'hAABB_CCDD;
      mem[10'h3FF] = 32'h600D_F00D;

      rst = 1'b1; vid_rd_en = 1'b0; vid_rd_addr = '0; host_req = 1'b0; host_addr = '0;
      tick(); tick(); settle();
      chk("rst_vid_valid", 64'(vid_rd_valid_a), 64'd0);
      chk("rst_host_rvalid", 64'(host_rvalid_a), 64'd0);
      chk("rst_ram_rdaddr", 64'(ram_rdaddr_a), 64'd0);
      chk("rst_vid_data", 64'(vid_rd_data_a), 64'd0);
      chk("rst_state", 64'(dut_a.state_q), 64'd0);

      // Single video read at 0x005.
      tick(); rst = 1'b0; vid_rd_en = 1'b1; vid_rd_addr = 10'h005; settle();
      chk("t1_addr", 64'(ram_rdaddr_a), 64'h005);
      chk("t1_gnt", 64'(host_gnt_a), 64'd0);
      tick(); vid_rd_en = 1'b0; settle();
      chk("t1_valid_c1", 64'(vid_rd_valid_a), 64'd0);
      chk("t1_addr_hold", 64'(ram_rdaddr_a), 64'h005);
      tick(); settle();
      chk("t1_valid_c2", 64'(vid_rd_valid_a), 64'd1);
      chk("t1_data", 64'(vid_rd_data_a), 64'hAABB_CCDD);
      chk("t1_host_rvalid", 64'(host_rvalid_a), 64'd0);
      chk("t1_host_timeout", 64'(host_timeout_a), 64'd0);
      tick(); settle();
      chk("t1_valid_c3", 64'(vid_rd_valid_a), 64'd0);
      chk("t1_data_hold", 64'(vid_rd_data_a), 64'hAABB_CCDD);

      // Eight back-to-back video reads, addresses 0..7.
      for (int k = 0; k < 10; k++) begin
         tick(); vid_rd_en = (k < 8); vid_rd_addr = ADDR_W'(k); settle();
         chk("t2_valid", 64'(vid_rd_valid_a), 64'(k >= 2));
         if (k >= 2) chk("t2_data", 64'(vid_rd_data_a), 64'(mem[k-2]));
      end
      tick(); settle();
      chk("t2_valid_end", 64'(vid_rd_valid_a), 64'd0);

      // Host read at 0x3FF with video idle.
      tick(); host_req = 1'b1; host_addr = 10'h3FF; settle();
      chk("t3_gnt", 64'(host_gnt_a), 64'd1);
      chk("t3_addr", 64'(ram_rdaddr_a), 64'h3FF);
      tick(); host_req = 1'b0; settle();
      chk("t3_gnt_off", 64'(host_gnt_a), 64'd0);
      chk("t3_inflight", 64'(dut_a.state_q), 64'd2);
      tick(); settle();
      chk("t3_rvalid", 64'(host_rvalid_a), 64'd1);
      chk("t3_rdata", 64'(host_rdata_a), 64'h600D_F00D);
      chk("t3_vid_valid", 64'(vid_rd_valid_a), 64'd0);
      tick(); settle();
      chk("t3_rvalid_off", 64'(host_rvalid_a), 64'd0);
      chk("t3_idle", 64'(dut_a.state_q), 64'd0);

      // Host request during a 5-cycle video burst.
      for (int k = 0; k < 8; k++) begin
         tick();
         vid_rd_en = (k < 5); vid_rd_addr = ADDR_W'(10'h010 + k);
         host_req = (k <= 5); host_addr = 10'h02A;
         settle();
         chk("t4_gnt", 64'(host_gnt_a), 64'(k == 5));
         chk("t4_addr", 64'(ram_rdaddr_a), (k < 5) ? 64'(10'h010 + k) : 64'h02A);
         chk("t4_vid_valid", 64'(vid_rd_valid_a), 64'(k >= 2 && k < 7));
         chk("t4_host_rvalid", 64'(host_rvalid_a), 64'(k == 7));
         chk("t4_b_timeout", 64'(host_timeout_b), 64'(k == 4));
         if (k == 7) chk("t4_rdata", 64'(host_rdata_a), 64'(mem[10'h02A]));
      end

      // Continuous video: instance b times out twice, instance a keeps waiting.
      for (int k = 0; k < 11; k++) begin
         tick(); vid_rd_en = 1'b1; vid_rd_addr = ADDR_W'(k); host_req = 1'b1; host_addr = 10'h055; settle();
         chk("t5_b_timeout", 64'(host_timeout_b), 64'(k == 4 || k == 9));
         chk("t5_b_gnt", 64'(host_gnt_b), 64'd0);
         chk("t5_a_gnt", 64'(host_gnt_a), 64'd0);
         chk("t5_a_timeout", 64'(host_timeout_a), 64'd0);
      end
      // Dropping the request in WAIT returns to IDLE with no pulse.
      tick(); host_req = 1'b0; vid_rd_en = 1'b0; settle();
      chk("t5_drop_gnt", 64'(host_gnt_a), 64'd0);
      chk("t5_drop_timeout", 64'(host_timeout_a), 64'd0);
      tick(); settle();
      chk("t5_drop_idle", 64'(dut_a.state_q), 64'd0);
      tick(); tick(); tick(); settle();

      // Reset one cycle after a host grant, during a video burst.
      tick(); host_req = 1'b1; host_addr = 10'h3FF; settle();
      chk("t6_gnt", 64'(host_gnt_a), 64'd1);
      tick(); host_req = 1'b0; vid_rd_en = 1'b1; vid_rd_addr = 10'h005; settle();
      rst = 1'b1; settle();
      chk("t6_rst_vid_valid", 64'(vid_rd_valid_a), 64'd0);
      chk("t6_rst_host_rvalid", 64'(host_rvalid_a), 64'd0);
      chk("t6_rst_gnt", 64'(host_gnt_a), 64'd0);
      chk("t6_rst_addr", 64'(ram_rdaddr_a), 64'd0);
      chk("t6_rst_vid_data", 64'(vid_rd_data_a), 64'd0);
      chk("t6_rst_host_data", 64'(host_rdata_a), 64'd0);
      chk("t6_rst_state", 64'(dut_a.state_q), 64'd0);
      tick(); vid_rd_en = 1'b0; settle();
      chk("t6_rst_vid_valid2", 64'(vid_rd_valid_a), 64'd0);
      tick(); rst = 1'b0; settle();
      for (int k = 0; k < 5; k++) begin
         chk("t6_post_vid_valid", 64'(vid_rd_valid_a), 64'd0);
         chk("t6_post_host_rvalid", 64'(host_rvalid_a), 64'd0);
         chk("t6_post_b_rvalid", 64'(host_rvalid_b), 64'd0);
         tick(); settle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
